// File: rtl/msg_arbiter_1030.sv
// msg_arbiter_1030: shares the 88-bit 1030 message channel between Mode A/C
// reply reports (buffered in a small FIFO) and the single-entry PPS drift
// report. Drift has priority. Output is valid/ready with zero-bubble reload.
module msg_arbiter_1030 #(
   parameter int          AC_FIFO_DEPTH = 4,
   parameter logic [2:0]  AC_TYPE       = 3'b011,
   parameter logic [2:0]  DRIFT_TYPE    = 3'b100,
   parameter logic [20:0] DRIFT_MARKER  = 21'h1FABAD
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic                              valid_mode_ac,
   input  logic [23:0]                       mode_ac_message,
   input  logic [25:0]                       mode_ac_clk_ts,
   input  logic [5:0]                        mode_ac_utc_ts,
   input  logic [12:0]                       mode_ac_drift,
   input  logic [15:0]                       device_id,
   input  logic                              valid_drift,
   input  logic [31:0]                       pps_count,
   input  logic [15:0]                       drift_message,
   input  logic                              out_ready,
   output logic                              out_valid,
   output logic [87:0]                       out_data,
   output logic                              out_is_drift,
   output logic [$clog2(AC_FIFO_DEPTH):0]    ac_fifo_level,
   output logic [15:0]                       ac_drop_count,
   output logic [15:0]                       drift_overwrite_count
);

   localparam int PTR_W = $clog2(AC_FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int PKT_W = 88;

   typedef enum logic {S_IDLE, S_PRESENT} state_t;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
      return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   endfunction

   // Mode A/C packet: device, UTC seconds, clock count, drift, type, reply.
   function automatic logic [PKT_W-1:0] pack_ac(
      input logic [15:0]        dev,
      input logic [5:0]         utc,
      input logic [25:0]        clk_ts,
      input logic signed [12:0] drift,
      input logic [23:0]        msg
   );
      return {dev, utc, clk_ts, $unsigned(drift), AC_TYPE, msg};
   endfunction

   // Drift packet: marker header, device, PPS count, type, drift value.
   function automatic logic [PKT_W-1:0] pack_drift(
      input logic [15:0]        dev,
      input logic [31:0]        pps,
      input logic signed [15:0] drift
   );
      return {DRIFT_MARKER, dev, pps, DRIFT_TYPE, $unsigned(drift)};
   endfunction

   // ---- stage p0: capture qualification and packing ----
   logic signed [12:0]  ac_drift_p0;
   logic signed [15:0]  drift_msg_p0;
   logic [PKT_W-1:0]    ac_pkt_p0;
   logic                cap_ac_p0;
   logic                cap_drift_p0;

   assign ac_drift_p0  = mode_ac_drift;
   assign drift_msg_p0 = drift_message;
   assign cap_ac_p0    = enable & valid_mode_ac;
   assign cap_drift_p0 = enable & valid_drift;
   assign ac_pkt_p0    = pack_ac(device_id, mode_ac_utc_ts, mode_ac_clk_ts,
                                 ac_drift_p0, mode_ac_message);

   // ---- stage p1: FIFO / drift holding register ----
   logic [PKT_W-1:0]    fifo_mem [AC_FIFO_DEPTH];
   logic [PTR_W:0]      wr_ptr;
   logic [PTR_W:0]      rd_ptr;
   logic                fifo_empty;
   logic                fifo_full;
   logic [PKT_W-1:0]    drift_pkt_p1;
   logic                drift_pending;
   state_t              state;
   state_t              state_nxt;
   logic                slot_free;
   logic                load_drift;
   logic                pop;
   logic                push;
   logic                drop;
   logic                overwrite;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   // The output register can take a new packet when idle or when the current
   // one is being accepted this edge (back-to-back reload, no bubble).
   assign slot_free  = (state == S_IDLE) || out_ready;
   assign load_drift = slot_free && drift_pending;
   assign pop        = slot_free && !drift_pending && !fifo_empty;
   // A full FIFO still accepts a report when the head leaves on the same edge.
   assign push       = cap_ac_p0 && (!fifo_full || pop);
   assign drop       = cap_ac_p0 && !push;
   // Only a report that replaces a still-unloaded entry counts as lost.
   assign overwrite  = cap_drift_p0 && drift_pending && !load_drift;

   assign ac_fifo_level = LVL_W'(wr_ptr - rd_ptr);

   // FIFO storage: data only, queue emptiness is carried by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= ac_pkt_p0;
      end
   end

   // FIFO pointers advance on push and pop independently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Drift holding register contents; the newest report always wins.
   always_ff @(posedge clk) begin
      if (cap_drift_p0) begin
         drift_pkt_p1 <= pack_drift(device_id, pps_count, drift_msg_p0);
      end
   end

   // Drift pending flag: a new capture takes precedence over the load clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drift_pending <= 1'b0;
      end else if (cap_drift_p0) begin
         drift_pending <= 1'b1;
      end else if (load_drift) begin
         drift_pending <= 1'b0;
      end
   end

   // Saturating loss counters for dropped Mode A/C and overwritten drift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ac_drop_count         <= '0;
         drift_overwrite_count <= '0;
      end else begin
         if (drop)      ac_drop_count         <= sat_inc16(ac_drop_count);
         if (overwrite) drift_overwrite_count <= sat_inc16(drift_overwrite_count);
      end
   end

   // ---- stage p2: output register and handshake FSM ----
   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: stay presenting as long as something is reloaded.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (load_drift || pop) state_nxt = S_PRESENT;
         end
         S_PRESENT: begin
            if (out_ready) begin
               state_nxt = (load_drift || pop) ? S_PRESENT : S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      out_valid = 1'b0;
      if (state == S_PRESENT) out_valid = 1'b1;
   end

   // Output packet register, held steady while the downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data     <= '0;
         out_is_drift <= 1'b0;
      end else if (load_drift) begin
         out_data     <= drift_pkt_p1;
         out_is_drift <= 1'b1;
      end else if (pop) begin
         out_data     <= fifo_mem[rd_ptr[PTR_W-1:0]];
         out_is_drift <= 1'b0;
      end
   end

endmodule

// File: tb/tb_msg_arbiter_1030.sv
// tb_msg_arbiter_1030: directed vectors for msg_arbiter_1030 with hand-built
// expected packets.
module tb_msg_arbiter_1030;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        valid_mode_ac;
   logic [23:0] mode_ac_message;
   logic [25:0] mode_ac_clk_ts;
   logic [5:0]  mode_ac_utc_ts;
   logic [12:0] mode_ac_drift;
   logic [15:0] device_id;
   logic        valid_drift;
   logic [31:0] pps_count;
   logic [15:0] drift_message;
   logic        out_ready;
   logic        out_valid;
   logic [87:0] out_data;
   logic        out_is_drift;
   logic [2:0]  ac_fifo_level;
   logic [15:0] ac_drop_count;
   logic [15:0] drift_overwrite_count;

   int n_chk = 0;
   int n_err = 0;
   int pulses;

   msg_arbiter_1030 dut (
      .clk                   (clk),
      .rst                   (rst),
      .enable                (enable),
      .valid_mode_ac         (valid_mode_ac),
      .mode_ac_message       (mode_ac_message),
      .mode_ac_clk_ts        (mode_ac_clk_ts),
      .mode_ac_utc_ts        (mode_ac_utc_ts),
      .mode_ac_drift         (mode_ac_drift),
      .device_id             (device_id),
      .valid_drift           (valid_drift),
      .pps_count             (pps_count),
      .drift_message         (drift_message),
      .out_ready             (out_ready),
      .out_valid             (out_valid),
      .out_data              (out_data),
      .out_is_drift          (out_is_drift),
      .ac_fifo_level         (ac_fifo_level),
      .ac_drop_count         (ac_drop_count),
      .drift_overwrite_count (drift_overwrite_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [87:0] got, input logic [87:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [87:0] ac_pkt(input logic [15:0] dev, input logic [5:0] utc,
                                          input logic [25:0] ts, input logic [12:0] dr,
                                          input logic [23:0] msg);
      return {dev, utc, ts, dr, 3'b011, msg};
   endfunction

   function automatic logic [87:0] dr_pkt(input logic [15:0] dev, input logic [31:0] pps,
                                          input logic [15:0] dm);
      return {21'h1FABAD, dev, pps, 3'b100, dm};
   endfunction

   // One-cycle Mode A/C strobe with the fixed side fields used below.
   task automatic send_ac(input logic [23:0] msg);
      mode_ac_message = msg;
      mode_ac_clk_ts  = 26'h0000100;
      mode_ac_utc_ts  = 6'd7;
      mode_ac_drift   = 13'h0012;
      device_id       = 16'h0042;
      valid_mode_ac   = 1'b1;
      tick();
      valid_mode_ac   = 1'b0;
   endtask

   task automatic send_drift(input logic [31:0] pps, input logic [15:0] dm);
      pps_count     = pps;
      drift_message = dm;
      device_id     = 16'h0042;
      valid_drift   = 1'b1;
      tick();
      valid_drift   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; out_ready = 1'b0;
      valid_mode_ac = 1'b0; valid_drift = 1'b0;
      mode_ac_message = '0; mode_ac_clk_ts = '0; mode_ac_utc_ts = '0;
      mode_ac_drift = '0; device_id = '0; pps_count = '0; drift_message = '0;
      repeat (3) tick();
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_level", ac_fifo_level, 0);
      check("rst_drop", ac_drop_count, 0);
      check("rst_ovw", drift_overwrite_count, 0);
      rst = 1'b0;
      tick();

      // 1: single Mode A/C report
      out_ready = 1'b1;
      mode_ac_message = 24'hABCDEF; mode_ac_clk_ts = 26'h123456;
      mode_ac_utc_ts = 6'd5; mode_ac_drift = 13'h1FFF; device_id = 16'h00A1;
      valid_mode_ac = 1'b1;
      tick();
      valid_mode_ac = 1'b0;
      check("t1_lat", out_valid, 0);
      tick();
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, {16'h00A1, 6'd5, 26'h123456, 13'h1FFF, 3'b011, 24'hABCDEF});
      check("t1_isdrift", out_is_drift, 0);
      tick();
      check("t1_done", out_valid, 0);
      pulses = 0;
      repeat (4) begin
         tick();
         if (out_valid) pulses++;
      end
      check("t1_extra", pulses, 0);

      // 2: simultaneous sources, drift wins
      mode_ac_message = 24'h222222; mode_ac_clk_ts = 26'h0000200;
      mode_ac_utc_ts = 6'd2; mode_ac_drift = 13'h0003; device_id = 16'h0B0B;
      pps_count = 32'd77; drift_message = 16'hFFF0;
      valid_mode_ac = 1'b1; valid_drift = 1'b1;
      tick();
      valid_mode_ac = 1'b0; valid_drift = 1'b0;
      tick();
      check("t2_valid0", out_valid, 1);
      check("t2_isdrift0", out_is_drift, 1);
      check("t2_marker", out_data[87:67], 21'h1FABAD);
      check("t2_type", out_data[18:16], 3'b100);
      check("t2_dpkt", out_data, dr_pkt(16'h0B0B, 32'd77, 16'hFFF0));
      tick();
      check("t2_valid1", out_valid, 1);
      check("t2_isdrift1", out_is_drift, 0);
      check("t2_apkt", out_data, ac_pkt(16'h0B0B, 6'd2, 26'h0000200, 13'h0003, 24'h222222));
      tick();
      check("t2_idle", out_valid, 0);

      // 3: stall with 6 strobes into a depth-4 FIFO
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) send_ac(24'h300000 + 24'(i));
      check("t3_valid", out_valid, 1);
      check("t3_level", ac_fifo_level, 4);
      check("t3_drop", ac_drop_count, 1);
      check("t3_hold0", out_data, ac_pkt(16'h0042, 6'd7, 26'h0000100, 13'h0012, 24'h300001));
      tick();
      check("t3_hold1", out_data, ac_pkt(16'h0042, 6'd7, 26'h0000100, 13'h0012, 24'h300001));
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         check($sformatf("t3_v%0d", i), out_valid, 1);
         check($sformatf("t3_d%0d", i), out_data,
               ac_pkt(16'h0042, 6'd7, 26'h0000100, 13'h0012, 24'h300000 + 24'(i)));
         tick();
      end
      check("t3_idle", out_valid, 0);
      check("t3_level0", ac_fifo_level, 0);

      // 4: drift overwrite while a Mode A/C packet is stalled
      out_ready = 1'b0;
      send_ac(24'h444444);
      tick();
      send_drift(32'd10, 16'h0001);
      send_drift(32'd11, 16'h0002);
      check("t4_ovw", drift_overwrite_count, 1);
      out_ready = 1'b1;
      check("t4_ac", out_data, ac_pkt(16'h0042, 6'd7, 26'h0000100, 13'h0012, 24'h444444));
      tick();
      check("t4_dvalid", out_valid, 1);
      check("t4_dpkt", out_data, dr_pkt(16'h0042, 32'd11, 16'h0002));
      tick();
      check("t4_idle", out_valid, 0);

      // 5: reset mid-transfer
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send_ac(24'h500000 + 24'(i));
      check("t5_valid", out_valid, 1);
      check("t5_level", ac_fifo_level, 3);
      #2 rst = 1'b1;
      #1;
      check("t5_rvalid", out_valid, 0);
      check("t5_rlevel", ac_fifo_level, 0);
      check("t5_rdrop", ac_drop_count, 0);
      check("t5_rovw", drift_overwrite_count, 0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      pulses = 0;
      repeat (6) begin
         tick();
         if (out_valid) pulses++;
      end
      check("t5_none", pulses, 0);

      // 6: enable low ignores strobes, queued item still drains
      out_ready = 1'b0;
      send_ac(24'h666666);
      tick();
      enable = 1'b0;
      mode_ac_message = 24'h777777; pps_count = 32'd99; drift_message = 16'h0009;
      valid_mode_ac = 1'b1; valid_drift = 1'b1;
      repeat (2) tick();
      valid_mode_ac = 1'b0; valid_drift = 1'b0;
      check("t6_level", ac_fifo_level, 0);
      check("t6_drop", ac_drop_count, 0);
      check("t6_ovw", drift_overwrite_count, 0);
      out_ready = 1'b1;
      check("t6_valid", out_valid, 1);
      check("t6_data", out_data, ac_pkt(16'h0042, 6'd7, 26'h0000100, 13'h0012, 24'h666666));
      pulses = 0;
      repeat (5) begin
         tick();
         if (out_valid) pulses++;
      end
      check("t6_none", pulses, 0);
      enable = 1'b1;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
